// File: rtl/goertzel_result_arbiter_pkg.sv
// goertzel_pkg: shared constants, helper function and FSM encoding for
// goertzel_result_arbiter.
//   OW_DEFAULT    default width of each Re/Im half
//   RES_W_DEFAULT result beat width (2*OW) for the default OW
//   clog2_min1()  channel-ID width, never less than 1 bit
//   arb_state_t   output FSM state encoding (ARB_IDLE, ARB_OUT)
package goertzel_pkg;

  localparam int OW_DEFAULT    = 20;
  localparam int RES_W_DEFAULT = 2 * OW_DEFAULT;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OUT  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/goertzel_result_arbiter_if.sv
// goertzel_result_arbiter_if: stream bundle between the goertzel channels,
// the arbiter and the downstream consumer.
//   s_axis_tdata  NCH packed {Re, Im} results, channel i at [i*2*OW +: 2*OW]
//   s_axis_tvalid per-channel result strobe
//   s_axis_tready per-channel ready (arbiter never stalls a source)
//   m_axis_*      merged output stream, tuser carries the channel ID
// Modports: slave = arbiter side, master = source/sink side driving it.
interface goertzel_result_arbiter_if
  import goertzel_pkg::*;
#(
  parameter int NCH = 4,
  parameter int OW  = OW_DEFAULT
);
  localparam int CW = clog2_min1(NCH);

  logic [NCH*2*OW-1:0] s_axis_tdata;
  logic [NCH-1:0]      s_axis_tvalid;
  logic [NCH-1:0]      s_axis_tready;
  logic [2*OW-1:0]     m_axis_tdata;
  logic [CW-1:0]       m_axis_tuser;
  logic                m_axis_tlast;
  logic                m_axis_tvalid;
  logic                m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tlast, m_axis_tvalid
  );

endinterface

// File: rtl/goertzel_result_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req       request vector (one bit per channel)
//   ptr       last granted channel; search starts at ptr+1 and wraps
//   gnt_valid some request was found
//   gnt_idx   index of the winning channel
module rr_pick
  import goertzel_pkg::*;
#(
  parameter int NCH = 4,
  localparam int CW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic           gnt_valid,
  output logic [CW-1:0]  gnt_idx
);

  always_comb begin
    logic [CW-1:0] idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    // Walk the NCH candidates in priority order; the first hit is kept.
    for (int k = 1; k <= NCH; k++) begin
      idx = CW'((int'(ptr) + k) % NCH);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/goertzel_result_arbiter.sv
// goertzel_result_arbiter: merges results from NCH goertzel channels onto one
// stream. Each channel has a 1-deep holding slot, so sources never stall;
// an arrival into a still-full slot overwrites it and flags o_overflow.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   bus           goertzel_result_arbiter_if.slave (s_axis in, m_axis out)
//   i_ovf_clr     pulse clearing o_overflow (and drop counters)
//   o_overflow    sticky per-channel "result overwritten" flag
//   o_drop_cnt    per-channel saturating drop counts
// Optional: define GOERTZEL_ARB_DROP_CNT_EN to build the drop counters;
// otherwise o_drop_cnt is tied to zero.
module goertzel_result_arbiter
  import goertzel_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int OW    = OW_DEFAULT,
  parameter int DROPW = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  goertzel_result_arbiter_if.slave bus,
  input  logic                   i_ovf_clr,
  output logic [NCH-1:0]         o_overflow,
  output logic [NCH*DROPW-1:0]   o_drop_cnt
);

  localparam int CW = clog2_min1(NCH);
  localparam int RW = 2 * OW;

  arb_state_t     state_reg, state_next;
  logic [RW-1:0]  slot_data_reg [NCH];
  logic [NCH-1:0] full_reg, full_next;
  logic [CW-1:0]  ptr_reg;
  logic [RW-1:0]  tdata_reg;
  logic [CW-1:0]  tuser_reg;
  logic           tlast_reg;
  logic [NCH-1:0] overflow_reg;
  logic [NCH-1:0] ovf_event;
  logic           gnt_valid;
  logic [CW-1:0]  gnt_idx;
  logic           grant_en;
  logic           tvalid_next;
  logic [NCH-1:0] gnt_onehot;

  rr_pick #(.NCH(NCH)) u_rr_pick (
    .req       (full_reg),
    .ptr       (ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_next  = state_reg;
    grant_en    = 1'b0;
    tvalid_next = 1'b0;
    case (state_reg)
      ARB_IDLE: begin
        if (gnt_valid) begin
          grant_en   = 1'b1;
          state_next = ARB_OUT;
        end
      end
      ARB_OUT: begin
        tvalid_next = 1'b1;
        // Accepting a beat with another slot pending re-grants immediately.
        if (bus.m_axis_tready) begin
          if (gnt_valid) grant_en = 1'b1;
          else           state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  assign gnt_onehot = grant_en ? (NCH'(1) << gnt_idx) : '0;
  // A same-cycle arrival on the granted channel refills its slot.
  assign full_next  = bus.s_axis_tvalid | (full_reg & ~gnt_onehot);
  assign ovf_event  = bus.s_axis_tvalid & full_reg & ~gnt_onehot;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (bus.s_axis_tvalid[i]) slot_data_reg[i] <= bus.s_axis_tdata[i*RW +: RW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ARB_IDLE;
      full_reg     <= '0;
      ptr_reg      <= CW'(NCH - 1);
      tdata_reg    <= '0;
      tuser_reg    <= '0;
      tlast_reg    <= 1'b0;
      overflow_reg <= '0;
    end else begin
      state_reg    <= state_next;
      full_reg     <= full_next;
      overflow_reg <= ovf_event | (i_ovf_clr ? '0 : overflow_reg);
      if (grant_en) begin
        tdata_reg <= slot_data_reg[gnt_idx];
        tuser_reg <= gnt_idx;
        // Last of burst when nothing else was waiting (new arrivals ignored).
        tlast_reg <= ((full_reg & ~gnt_onehot) == '0);
        ptr_reg   <= gnt_idx;
      end
    end
  end

  assign bus.s_axis_tready = '1;
  assign bus.m_axis_tdata  = tdata_reg;
  assign bus.m_axis_tuser  = tuser_reg;
  assign bus.m_axis_tlast  = tlast_reg;
  assign bus.m_axis_tvalid = tvalid_next;
  assign o_overflow        = overflow_reg;

`ifdef GOERTZEL_ARB_DROP_CNT_EN
  logic [DROPW-1:0] drop_cnt_reg [NCH];

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (i_rst) begin
        drop_cnt_reg[i] <= '0;
      end else if (ovf_event[i]) begin
        if (drop_cnt_reg[i] != '1) drop_cnt_reg[i] <= drop_cnt_reg[i] + 1'b1;
      end else if (i_ovf_clr) begin
        drop_cnt_reg[i] <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_drop
    assign o_drop_cnt[gi*DROPW +: DROPW] = drop_cnt_reg[gi];
  end
`else
  assign o_drop_cnt = '0;
`endif

endmodule
